// File: rtl/loader_pkg.sv
// Shared frame-format constants and loader FSM state encoding.
// Used by the instruction-memory loader and its byte packer.
package loader_pkg;

  typedef enum logic [2:0] {
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  localparam int LEN_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;
  localparam int CSUM_W         = 8;
  localparam int WORD_W         = 8 * BYTES_PER_WORD;
  localparam int BCNT_W         = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/byte_packer.sv
// Packs a byte strobe stream into little-endian words; word_vld pulses the cycle after the last byte.
// Latency 1 cycle from final byte; no backpressure (strobe input, at most one word per 4 bytes).
module byte_packer
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              byte_vld,
  input  logic [7:0]        byte_dat,
  output logic              word_end,
  output logic              word_vld,
  output logic [WORD_W-1:0] word_dat
);

  logic [BCNT_W-1:0] byte_cnt;
  logic [WORD_W-1:0] shreg;
  logic [WORD_W-1:0] next_word;

  // New bytes enter at the top so the first byte of a word ends up in bits 7:0.
  assign next_word = {byte_dat, shreg[WORD_W-1:8]};
  assign word_end  = byte_vld && (byte_cnt == BCNT_W'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      byte_cnt <= '0;
      shreg    <= '0;
      word_vld <= 1'b0;
      word_dat <= '0;
    end else begin
      word_vld <= word_end;
      if (byte_vld) begin
        byte_cnt <= byte_cnt + BCNT_W'(1);
        shreg    <= next_word;
        if (word_end) word_dat <= next_word;
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: length-prefixed byte frame -> sequential imem writes, core held until checksum matches.
// Latency 1 cycle per write/flag; no backpressure (UART strobe, one write per 4 bytes at most).
module imem_loader
  import loader_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter int          MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_hold,
  output logic        load_done,
  output logic        load_err
);

  state_t            state;
  logic [7:0]        count_lo;
  logic [15:0]       count;
  logic [15:0]       index;
  logic [CSUM_W-1:0] acc;
  logic              data_strobe;
  logic              word_end;
  logic [15:0]       len_word;

  assign data_strobe = byte_valid && (state == S_DATA);
  assign len_word    = {byte_data, count_lo};

  byte_packer u_packer (
    .clk      (clk),
    .reset    (reset),
    .byte_vld (data_strobe),
    .byte_dat (byte_data),
    .word_end (word_end),
    .word_vld (imem_we),
    .word_dat (imem_wdata)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_LEN_LO;
      count_lo  <= '0;
      count     <= '0;
      index     <= '0;
      acc       <= '0;
      imem_addr <= ADDR_BASE;
      core_hold <= 1'b1;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else if (byte_valid) begin
      case (state)
        S_LEN_LO: begin
          count_lo <= byte_data;
          state    <= S_LEN_HI;
        end
        S_LEN_HI: begin
          count <= len_word;
          if (32'(len_word) > MAX_WORDS) begin
            state    <= S_ERR;
            load_err <= 1'b1;
          end else if (len_word == 16'd0) begin
            state <= S_CSUM;
          end else begin
            state <= S_DATA;
          end
        end
        S_DATA: begin
          acc <= acc + byte_data;
          // Address is registered alongside the packer's word so both land in the write cycle.
          if (word_end) begin
            imem_addr <= ADDR_BASE + {14'd0, index, 2'b00};
            index     <= index + 16'd1;
            if (index == count - 16'd1) state <= S_CSUM;
          end
        end
        S_CSUM: begin
          if (byte_data == acc) begin
            state     <= S_DONE;
            load_done <= 1'b1;
            core_hold <= 1'b0;
          end else begin
            state    <= S_ERR;
            load_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: two instances (base 0x0 and 0x100) share the same byte stream.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;

  logic        we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        hold0, hold1, done0, done1, err0, err1;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] wa0[$], wd0[$], wa1[$], wd1[$];

  logic [7:0] frame[11] = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                            8'h93, 8'h00, 8'h50, 8'h00, 8'hF6};

  always #5 clk = ~clk;

  imem_loader #(.ADDR_BASE(32'h0000_0000), .MAX_WORDS(256)) u_dut0 (
    .clk(clk), .reset(reset), .byte_valid(byte_valid), .byte_data(byte_data),
    .imem_we(we0), .imem_addr(addr0), .imem_wdata(wdata0),
    .core_hold(hold0), .load_done(done0), .load_err(err0)
  );

  imem_loader #(.ADDR_BASE(32'h0000_0100), .MAX_WORDS(256)) u_dut1 (
    .clk(clk), .reset(reset), .byte_valid(byte_valid), .byte_data(byte_data),
    .imem_we(we1), .imem_addr(addr1), .imem_wdata(wdata1),
    .core_hold(hold1), .load_done(done1), .load_err(err1)
  );

  // Write logger, sampled 1 time unit after the active edge.
  always @(posedge clk) begin
    #1;
    if (we0) begin wa0.push_back(addr0); wd0.push_back(wdata0); end
    if (we1) begin wa1.push_back(addr1); wd1.push_back(wdata1); end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte was accepted.
  task automatic send(input logic [7:0] b);
    byte_valid = 1'b1;
    byte_data  = b;
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle(2);
    reset = 1'b1;
    wa0.delete(); wd0.delete(); wa1.delete(); wd1.delete();
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_we"},    32'(we0),   32'd0);
    check_val({tag, "_addr"},  addr0,      32'h0);
    check_val({tag, "_wdata"}, wdata0,     32'h0);
    check_val({tag, "_hold"},  32'(hold0), 32'd1);
    check_val({tag, "_done"},  32'(done0), 32'd0);
    check_val({tag, "_err"},   32'(err0),  32'd0);
    check_val({tag, "_addr1"}, addr1,      32'h100);
  endtask

  task automatic send_frame(input logic [7:0] csum, input int maxgap);
    for (int i = 0; i < 11; i++) begin
      send(i == 10 ? csum : frame[i]);
      if (maxgap > 0 && i < 10) idle($urandom_range(maxgap, 0));
    end
  endtask

  task automatic check_sweep(input string tag);
    check_val({tag, "_nwr"},  32'(wa1.size()), 32'd2);
    if (wa1.size() == 2) begin
      check_val({tag, "_a0"}, wa1[0], 32'h100);
      check_val({tag, "_d0"}, wd1[0], 32'h0000_0013);
      check_val({tag, "_a1"}, wa1[1], 32'h104);
      check_val({tag, "_d1"}, wd1[1], 32'h0050_0093);
    end
    check_val({tag, "_done"}, 32'(done1), 32'd1);
    check_val({tag, "_hold"}, 32'(hold1), 32'd0);
    check_val({tag, "_err"},  32'(err1),  32'd0);
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    check_reset_vals("rst");

    // Nominal two-word load with per-write timing checks.
    send(8'h02); send(8'h00);
    send(8'h13); send(8'h00); send(8'h00);
    check_val("nom_we_early", 32'(we0), 32'd0);
    send(8'h00);
    check_val("nom_we0",    32'(we0), 32'd1);
    check_val("nom_addr0",  addr0,    32'h0);
    check_val("nom_wdata0", wdata0,   32'h0000_0013);
    send(8'h93);
    check_val("nom_we_pulse", 32'(we0), 32'd0);
    send(8'h00); send(8'h50); send(8'h00);
    check_val("nom_we1",    32'(we0), 32'd1);
    check_val("nom_addr1",  addr0,    32'h4);
    check_val("nom_wdata1", wdata0,   32'h0050_0093);
    check_val("nom_done_pre", 32'(done0), 32'd0);
    send(8'hF6);
    check_val("nom_done", 32'(done0), 32'd1);
    check_val("nom_hold", 32'(hold0), 32'd0);
    check_val("nom_err",  32'(err0),  32'd0);
    send(8'h13); send(8'h00); send(8'h00); send(8'h00);
    idle(2);
    check_val("nom_nwr_after_done", 32'(wa0.size()), 32'd2);
    check_val("nom_done_sticky", 32'(done0), 32'd1);
    check_val("nom_err_after_done", 32'(err0), 32'd0);

    // Bad checksum.
    do_reset();
    send_frame(8'hF5, 0);
    check_val("bad_err",  32'(err0),  32'd1);
    check_val("bad_hold", 32'(hold0), 32'd1);
    check_val("bad_done", 32'(done0), 32'd0);
    idle(2);
    check_val("bad_nwr",  32'(wa0.size()), 32'd2);

    // Empty image.
    do_reset();
    send(8'h00); send(8'h00); send(8'h00);
    check_val("empty_done", 32'(done0), 32'd1);
    check_val("empty_hold", 32'(hold0), 32'd0);
    idle(2);
    check_val("empty_nwr", 32'(wa0.size()), 32'd0);

    // Oversize image (257 words).
    do_reset();
    send(8'h01);
    check_val("big_err_early", 32'(err0), 32'd0);
    send(8'h01);
    check_val("big_err",  32'(err0),  32'd1);
    check_val("big_hold", 32'(hold0), 32'd1);
    for (int i = 0; i < 8; i++) send(8'(i + 1));
    idle(2);
    check_val("big_nwr",  32'(wa0.size()), 32'd0);
    check_val("big_err_sticky", 32'(err0), 32'd1);
    check_val("big_done", 32'(done0), 32'd0);

    // Reset after 6 payload bytes, then replay.
    do_reset();
    for (int i = 0; i < 8; i++) send(frame[i]);
    idle(2);
    check_val("mid_nwr", 32'(wa0.size()), 32'd1);
    do_reset();
    check_reset_vals("mid_rst");
    send_frame(8'hF6, 0);
    check_val("mid_done", 32'(done0), 32'd1);
    idle(2);
    check_val("mid_nwr2", 32'(wa0.size()), 32'd2);
    if (wa0.size() == 2) begin
      check_val("mid_a0", wa0[0], 32'h0);
      check_val("mid_d1", wd0[1], 32'h0050_0093);
    end

    // Reset asserted while a byte is presented: that byte must be dropped.
    reset = 1'b0;
    send(8'h00);
    reset = 1'b1;
    send(8'h00); send(8'h00); send(8'h00);
    check_val("rstbyte_done", 32'(done0), 32'd1);

    // Timing sweep at ADDR_BASE=0x100: back-to-back, then random gaps.
    do_reset();
    send_frame(8'hF6, 0);
    idle(2);
    check_sweep("b2b");
    do_reset();
    send_frame(8'hF6, 20);
    idle(2);
    check_sweep("gap");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
